// File: rtl/i2c_slave_tx_sequencer_if.sv
// I2C slave transmit sequencer bus: strobes, SDA sample, byte handshake and
// line-control outputs. master drives the inputs, slave is the sequencer.
interface i2c_slave_tx_sequencer_if;
  logic       go;
  logic       start;
  logic       stop;
  logic       rising_edge;
  logic       falling_edge;
  logic       sda_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sda_drive_low;
  logic       byte_sent;
  logic       ack_received;
  logic       nack_received;
  logic       tx_underrun;
  logic       scl_hold;
  logic       busy;

  modport master (
    output go,
    output start,
    output stop,
    output rising_edge,
    output falling_edge,
    output sda_in,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  sda_drive_low,
    input  byte_sent,
    input  ack_received,
    input  nack_received,
    input  tx_underrun,
    input  scl_hold,
    input  busy
  );

  modport slave (
    input  go,
    input  start,
    input  stop,
    input  rising_edge,
    input  falling_edge,
    input  sda_in,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output sda_drive_low,
    output byte_sent,
    output ack_received,
    output nack_received,
    output tx_underrun,
    output scl_hold,
    output busy
  );
endinterface

// File: rtl/i2c_slave_tx_sequencer.sv
// I2C slave transmit bit sequencer for master-read transfers: shifts bytes
// MSB-first on SCL falls, samples master ACK/NACK on the 9th SCL rise.
// Ports: clk, rst (sync, active-high), bus (slave modport): go/start/stop,
//   rising_edge/falling_edge strobes, sda_in, tx_data/tx_valid/tx_ready,
//   sda_drive_low, byte_sent, ack_received, nack_received, tx_underrun,
//   scl_hold, busy. All outputs registered.
// Option: define I2C_TX_STRETCH_EN to stretch SCL on underrun instead of
//   sending IDLE_FILL.
module i2c_slave_tx_sequencer #(
  parameter logic [7:0] IDLE_FILL = 8'hFF
) (
  input logic clk,
  input logic rst,
  i2c_slave_tx_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    ACK_WAIT = 3'd2,
    ACK_HOLD = 3'd3,
    STALL    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  // MSB goes straight onto SDA at load, so only the
  // remaining seven bits are held for shifting.
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       nack_q, nack_d;
  logic       sda_q, sda_d;
  logic       rdy_q, rdy_d;
  logic       sent_q, sent_d;
  logic       ack_q, ack_d;
  logic       nrx_q, nrx_d;
  logic       busy_q;
  logic       load;
  logic       underrun;
`ifdef I2C_TX_STRETCH_EN
  logic       hold_q, hold_d;
`else
  logic       under_q, under_d;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    nack_d   = nack_q;
    sda_d    = sda_q;
    rdy_d    = 1'b0;
    sent_d   = 1'b0;
    ack_d    = 1'b0;
    nrx_d    = 1'b0;
    load     = 1'b0;
    underrun = 1'b0;
`ifdef I2C_TX_STRETCH_EN
    hold_d   = hold_q;
`else
    under_d  = 1'b0;
`endif

    if (state_q != IDLE && (bus.start || bus.stop)) begin
      state_d = IDLE;
      sda_d   = 1'b0;
`ifdef I2C_TX_STRETCH_EN
      hold_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.go) begin
            load     = bus.tx_valid;
            underrun = ~bus.tx_valid;
          end
        end
        SHIFT: begin
          if (bus.falling_edge) begin
            if (cnt_q == 3'd7) begin
              sda_d   = 1'b0;
              sent_d  = 1'b1;
              state_d = ACK_WAIT;
            end else begin
              shift_d = {shift_q[5:0], 1'b0};
              cnt_d   = cnt_q + 3'd1;
              sda_d   = ~shift_q[6];
            end
          end
        end
        ACK_WAIT: begin
          if (bus.rising_edge) begin
            ack_d   = ~bus.sda_in;
            nrx_d   = bus.sda_in;
            nack_d  = bus.sda_in;
            state_d = ACK_HOLD;
          end
        end
        ACK_HOLD: begin
          if (bus.falling_edge) begin
            if (nack_q) begin
              state_d = IDLE;
              sda_d   = 1'b0;
            end else begin
              load     = bus.tx_valid;
              underrun = ~bus.tx_valid;
            end
          end
        end
        STALL: begin
`ifdef I2C_TX_STRETCH_EN
          load = bus.tx_valid;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      shift_d = bus.tx_data[6:0];
      cnt_d   = 3'd0;
      sda_d   = ~bus.tx_data[7];
      rdy_d   = 1'b1;
      state_d = SHIFT;
`ifdef I2C_TX_STRETCH_EN
      hold_d  = 1'b0;
`endif
    end

    if (underrun) begin
`ifdef I2C_TX_STRETCH_EN
      state_d = STALL;
      hold_d  = 1'b1;
      sda_d   = 1'b0;
`else
      shift_d = IDLE_FILL[6:0];
      cnt_d   = 3'd0;
      sda_d   = ~IDLE_FILL[7];
      under_d = 1'b1;
      state_d = SHIFT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      nack_q  <= 1'b0;
      sda_q   <= 1'b0;
      rdy_q   <= 1'b0;
      sent_q  <= 1'b0;
      ack_q   <= 1'b0;
      nrx_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef I2C_TX_STRETCH_EN
      hold_q  <= 1'b0;
`else
      under_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      nack_q  <= nack_d;
      sda_q   <= sda_d;
      rdy_q   <= rdy_d;
      sent_q  <= sent_d;
      ack_q   <= ack_d;
      nrx_q   <= nrx_d;
      busy_q  <= (state_d != IDLE);
`ifdef I2C_TX_STRETCH_EN
      hold_q  <= hold_d;
`else
      under_q <= under_d;
`endif
    end
  end

  assign bus.tx_ready      = rdy_q;
  assign bus.sda_drive_low = sda_q;
  assign bus.byte_sent     = sent_q;
  assign bus.ack_received  = ack_q;
  assign bus.nack_received = nrx_q;
  assign bus.busy          = busy_q;
`ifdef I2C_TX_STRETCH_EN
  assign bus.scl_hold      = hold_q;
  assign bus.tx_underrun   = 1'b0;
`else
  assign bus.scl_hold      = 1'b0;
  assign bus.tx_underrun   = under_q;
`endif

endmodule

// File: tb/tb_i2c_slave_tx_sequencer.sv
// Bench for i2c_slave_tx_sequencer: directed scenarios plus random traffic,
// checked every cycle against a transfer-level model.
module tb_i2c_slave_tx_sequencer;
  localparam logic [7:0] FILL = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  int   n_rdy = 0;

  i2c_slave_tx_sequencer_if bus();

  i2c_slave_tx_sequencer #(.IDLE_FILL(FILL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: a byte in flight, count of SCL falls since it
  // was loaded, whether the ACK slot has been sampled, stall flag.
  bit         m_en = 0;
  bit         m_busy, m_stall, m_smp, m_nk;
  int         m_nf;
  logic [7:0] m_by;
  bit         m_sda, m_hold, m_rdy, m_sent, m_ack, m_nrx, m_und;

  always @(posedge clk) begin : model
    bit busy, stall, smp, nk, sda, hold, rdy, sent, ack, nrx, und;
    bit ld, ur, nb;
    int nf;
    logic [7:0] by, nd;
    busy = m_busy; stall = m_stall; smp = m_smp; nk = m_nk;
    nf = m_nf; by = m_by; sda = m_sda; hold = m_hold;
    rdy = 0; sent = 0; ack = 0; nrx = 0; und = 0;
    ld = 0; ur = 0; nb = 0; nd = 8'h00;
    if (rst) begin
      busy = 0; stall = 0; smp = 0; nk = 0;
      nf = 0; by = 0; sda = 0; hold = 0;
    end else if (busy && (bus.start || bus.stop)) begin
      busy = 0; stall = 0; sda = 0; hold = 0;
    end else if (!busy) begin
      if (bus.go) begin
        ld = bus.tx_valid; ur = !bus.tx_valid;
      end
    end else if (stall) begin
      ld = bus.tx_valid;
    end else if (nf < 8) begin
      if (bus.falling_edge) begin
        nf++;
        if (nf == 8) begin
          sda = 0; sent = 1;
        end else begin
          sda = !by[7 - nf];
        end
      end
    end else if (!smp) begin
      if (bus.rising_edge) begin
        smp = 1; nk = bus.sda_in;
        ack = !bus.sda_in; nrx = bus.sda_in;
      end
    end else if (bus.falling_edge) begin
      if (nk) begin
        busy = 0; sda = 0;
      end else begin
        ld = bus.tx_valid; ur = !bus.tx_valid;
      end
    end
    if (ld) begin
      nb = 1; nd = bus.tx_data; rdy = 1;
    end
    if (ur) begin
`ifdef I2C_TX_STRETCH_EN
      busy = 1; stall = 1; hold = 1; sda = 0;
`else
      nb = 1; nd = FILL; und = 1;
`endif
    end
    if (nb) begin
      by = nd; nf = 0; smp = 0; sda = !nd[7];
      busy = 1; stall = 0; hold = 0;
    end
    m_busy <= busy; m_stall <= stall; m_smp <= smp; m_nk <= nk;
    m_nf <= nf; m_by <= by; m_sda <= sda; m_hold <= hold;
    m_rdy <= rdy; m_sent <= sent; m_ack <= ack; m_nrx <= nrx;
    m_und <= und;
    if (rst) m_en <= 1;
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("tx_ready", bus.tx_ready, m_rdy);
      chk("sda_drive_low", bus.sda_drive_low, m_sda);
      chk("byte_sent", bus.byte_sent, m_sent);
      chk("ack_received", bus.ack_received, m_ack);
      chk("nack_received", bus.nack_received, m_nrx);
      chk("tx_underrun", bus.tx_underrun, m_und);
      chk("scl_hold", bus.scl_hold, m_hold);
      chk("busy", bus.busy, m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.tx_ready === 1'b1) n_rdy++;
  endtask

  task automatic clear();
    rst = 0;
    bus.go = 0;
    bus.start = 0;
    bus.stop = 0;
    bus.rising_edge = 0;
    bus.falling_edge = 0;
  endtask

  task automatic fall();
    clear(); bus.falling_edge = 1; tick();
  endtask

  task automatic rise(input logic s);
    clear(); bus.sda_in = s; bus.rising_edge = 1; tick();
  endtask

  task automatic go(input logic [7:0] d);
    clear(); bus.tx_valid = 1; bus.tx_data = d; bus.go = 1; tick();
    bus.tx_valid = 0;
  endtask

  task automatic idle();
    clear(); tick();
  endtask

  logic [7:0] seq;
  logic       acc;
  int         hcnt;

  initial begin
    clear();
    rst = 1;
    bus.sda_in = 1;
    bus.tx_valid = 0;
    bus.tx_data = 8'h00;
    tick(); tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_sda", bus.sda_drive_low, 0);
    chk("reset_rdy", bus.tx_ready, 0);
    clear(); tick();

    // A5 then NACK
    n_rdy = 0;
    go(8'hA5);
    seq[7] = bus.sda_drive_low;
    for (int i = 1; i < 8; i++) begin
      fall(); seq[7 - i] = bus.sda_drive_low;
    end
    chk("a5_sda_seq", seq, 8'h5A);
    fall();
    chk("a5_byte_sent", bus.byte_sent, 1);
    chk("a5_release", bus.sda_drive_low, 0);
    rise(1);
    chk("a5_nack", bus.nack_received, 1);
    fall();
    chk("a5_idle", bus.busy, 0);
    chk("a5_rdy_count", n_rdy, 1);
    idle();

    // 3C, ACK, FF
    n_rdy = 0;
    go(8'h3C);
    repeat (8) fall();
    rise(0);
    chk("two_ack", bus.ack_received, 1);
    bus.tx_valid = 1; bus.tx_data = 8'hFF;
    fall();
    bus.tx_valid = 0;
    chk("two_rdy2", bus.tx_ready, 1);
    acc = bus.sda_drive_low;
    for (int i = 0; i < 7; i++) begin
      fall(); acc = acc | bus.sda_drive_low;
    end
    chk("two_ff_released", acc, 0);
    fall();
    chk("two_sent2", bus.byte_sent, 1);
    chk("two_rdy_count", n_rdy, 2);
    rise(1);
    fall();
    idle();

    // STOP mid-byte
    go(8'h00);
    chk("stop_msb", bus.sda_drive_low, 1);
    repeat (3) fall();
    clear(); bus.stop = 1; tick();
    chk("stop_sda", bus.sda_drive_low, 0);
    chk("stop_busy", bus.busy, 0);
    fall();
    chk("stop_after_fall", bus.busy, 0);
    idle();

    // Underrun after ACK
    go(8'h81);
    repeat (8) fall();
    rise(0);
    bus.tx_valid = 0;
    fall();
`ifdef I2C_TX_STRETCH_EN
    hcnt = int'(bus.scl_hold);
    for (int i = 0; i < 4; i++) begin
      idle(); hcnt += int'(bus.scl_hold);
    end
    bus.tx_valid = 1; bus.tx_data = 8'h4C;
    idle();
    bus.tx_valid = 0;
    chk("stall_hold_cycles", hcnt, 5);
    chk("stall_hold_off", bus.scl_hold, 0);
    chk("stall_rdy", bus.tx_ready, 1);
    chk("stall_msb", bus.sda_drive_low, 1);
`else
    chk("under_pulse", bus.tx_underrun, 1);
    chk("under_no_rdy", bus.tx_ready, 0);
    chk("under_hold", bus.scl_hold, 0);
    acc = bus.sda_drive_low;
    for (int i = 0; i < 7; i++) begin
      fall(); acc = acc | bus.sda_drive_low;
    end
    chk("under_fill_released", acc, 0);
`endif
    repeat (8) fall();
    rise(1);
    fall();
    idle();

    // Reset during ACK_WAIT
    go(8'h12);
    repeat (8) fall();
    clear(); rst = 1; tick();
    chk("rst_outputs",
        {bus.tx_ready, bus.sda_drive_low, bus.byte_sent, bus.ack_received,
         bus.nack_received, bus.tx_underrun, bus.scl_hold, bus.busy}, 0);
    go(8'h12);
    chk("rst_go_busy", bus.busy, 1);
    chk("rst_go_rdy", bus.tx_ready, 1);
    chk("rst_go_msb", bus.sda_drive_low, 1);
    clear(); bus.stop = 1; tick();
    idle();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      clear();
      rst = ($urandom_range(499) == 0);
      bus.go = ($urandom_range(9) == 0);
      bus.start = ($urandom_range(79) == 0);
      bus.stop = ($urandom_range(79) == 0);
      bus.rising_edge = ($urandom_range(9) < 3);
      bus.falling_edge = ($urandom_range(9) < 3);
      bus.sda_in = $urandom_range(1);
      bus.tx_valid = ($urandom_range(9) < 7);
      bus.tx_data = 8'($urandom);
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_tx_sequencer.md
Name: i2c_slave_tx_sequencer

Overview:
- I2C slave transmit-side bit sequencer for master-read transfers.
- The slave controller issues `go` once the address phase with R/W=1 has been ACKed and SCL is low.
- The block shifts bytes out MSB-first on SCL falling edges, then samples the master's ACK/NACK on the 9th SCL rising edge.
- It counterparts the slave receive timer; both consume the same single-cycle SCL edge strobes from the edge detector.

Parameters:
- IDLE_FILL, 8'hFF: byte transmitted on underrun when stretching is compiled out.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- go  input  1  single-cycle pulse: begin transmit phase; SCL is low
- start  input  1  single-cycle pulse: (repeated) START detected
- stop  input  1  single-cycle pulse: STOP detected
- rising_edge  input  1  single-cycle pulse: SCL rising edge
- falling_edge  input  1  single-cycle pulse: SCL falling edge
- sda_in  input  1  synchronized SDA level
- tx_data  input  8  next byte to transmit
- tx_valid  input  1  tx_data holds a byte
- tx_ready  output  1  single-cycle pulse: tx_data consumed this cycle
- sda_drive_low  output  1  1 = pull SDA low, 0 = release
- byte_sent  output  1  pulse: 8th data bit completed
- ack_received  output  1  pulse: master ACK sampled
- nack_received  output  1  pulse: master NACK sampled
- tx_underrun  output  1  pulse: fill byte loaded (only without I2C_TX_STRETCH_EN)
- scl_hold  output  1  request SCL stretch (only with I2C_TX_STRETCH_EN; tied 0 otherwise)
- busy  output  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset state is IDLE. All outputs are 0, shift_reg = 0, bit_cnt = 0, nack_flag = 0.
- FSM states: IDLE, SHIFT, ACK_WAIT, ACK_HOLD, STALL.
- Priority: rst > (start|stop) > state logic.
- start or stop in any non-IDLE state:
  - next state is IDLE, sda_drive_low = 0, scl_hold = 0.
  - Any pending edge strobe that cycle is ignored.
  - In IDLE, start and stop are no-ops.
- LOAD action (used by several states):
  - shift_reg <= tx_data, bit_cnt <= 0, sda_drive_low <= ~tx_data[7], tx_ready pulses the same cycle, next state is SHIFT.
  - The MSB is driven 1 cycle after the load decision, while SCL is still low.
- IDLE:
  - On go with tx_valid: LOAD.
  - On go without tx_valid: see Optional Feature.
  - go outside IDLE is ignored.
- SHIFT (examines falling_edge only):
  - bit_cnt < 7: shift_reg <= shift_reg << 1; bit_cnt++; sda_drive_low <= ~shift_reg[6].
  - bit_cnt == 7: sda_drive_low <= 0 (release for ACK); byte_sent pulses; next state is ACK_WAIT.
- ACK_WAIT (examines rising_edge only):
  - sda_in == 0: ack_received pulses, nack_flag <= 0.
  - sda_in == 1: nack_received pulses, nack_flag <= 1.
  - Next state is ACK_HOLD.
- ACK_HOLD (examines falling_edge only):
  - nack_flag: go to IDLE with SDA released.
  - Otherwise, tx_valid: LOAD.
  - Otherwise: underrun handling (Optional Feature).
- Each state examines exactly one edge type, so simultaneous rising_edge and falling_edge resolve deterministically.
- Latency: edge strobe at cycle N gives the output change at cycle N+1.
- bit_cnt is 3 bits and never wraps. After the 8th bit it is reloaded only by LOAD.
- Reset mid-byte releases SDA on the next cycle and abandons the byte. No tx_ready is issued.

Optional Feature:
- Macro: I2C_TX_STRETCH_EN.
- Defined:
  - Underrun (go or ACK_HOLD falling_edge without tx_valid) enters STALL with scl_hold <= 1 and sda_drive_low <= 0.
  - STALL on tx_valid: LOAD and scl_hold <= 0 in the same register update.
  - start or stop also clears scl_hold.
- Undefined:
  - Underrun performs LOAD using IDLE_FILL instead of tx_data.
  - tx_underrun pulses; tx_ready stays 0.
  - STALL is unreachable and scl_hold is tied 0.

Test Plan:
- Byte out, NACK:
  - Stimulus: go with tx_valid, tx_data = 8'hA5; 8 falling edges; then a rising edge with sda_in = 1.
  - Response: sda_drive_low sequence 0,1,0,1,1,0,1,0; tx_ready pulses once; byte_sent on the 8th falling edge; nack_received; IDLE after the next falling edge.
- Two bytes, ACK:
  - Stimulus: tx_data = 8'h3C then 8'hFF; ACK (sda_in = 0) after byte 1.
  - Response: ack_received; the ACK_HOLD falling edge loads 8'hFF; sda_drive_low = 0 throughout byte 2; second tx_ready pulse.
- STOP mid-byte:
  - Stimulus: stop after 3 bits of 8'h00.
  - Response: sda_drive_low = 0 and busy = 0 the next cycle; a subsequent falling_edge has no effect.
- Underrun with I2C_TX_STRETCH_EN defined:
  - Stimulus: ACK, then tx_valid = 0 at the falling edge; tx_valid rises 5 cycles later.
  - Response: scl_hold = 1 for 5 cycles, then 0 with the MSB driven and tx_ready pulsing.
- Underrun with I2C_TX_STRETCH_EN undefined:
  - Stimulus: same as above.
  - Response: tx_underrun pulses; 8'hFF transmitted (SDA released for all 8 bits); scl_hold stays 0.
- Reset:
  - Stimulus: rst asserted during ACK_WAIT.
  - Response: all outputs 0 the next cycle; go is accepted normally afterwards.
